sbuf_mc: RTL and testbench
==========================

Name: sbuf_mc

Overview:
Parametrised multi-channel output capture buffer for the systolic array output side. Captures NCH parallel result lanes and their saturation flags for a programmed number of write strobes, and packs saturation flags DW-per-word. Exposes everything to the bus through one synchronous read port. Next generation of the single-lane 16-bit sbuf; adds channel count, depth/width generics, overflow protection and partial-word flush.

Parameters:
DW, 16, data width per lane; also the number of saturation bits packed per word
AW, 8, RAM address width; depth per channel = 2**AW
NCH, 4, number of lanes; power of two, >=2
CW, 8, run counter width
CHW, $clog2(NCH), derived localparam; not overridable

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sbus_radr  in  CHW+1+AW  read address {ch, sel, word}; sel=0 data buffer, sel=1 saturation buffer
sbus_rdata  out  DW  read data, valid 1 cycle after sbus_radr
run_cntr  in  CW  number of strobes to capture, sampled on start
start  in  1  one-cycle run start pulse
s_running  out  1  capture in progress
finish  out  1  one-cycle pulse at end of run
s_out  in  NCH*DW  lane data, lane c at [c*DW +: DW]
sat  in  NCH  per-lane saturation flag
sw  in  1  write strobe, qualifies s_out/sat
wr_ovf  out  1  sticky: a strobe arrived with data address at 2**AW-1 already written
sat_total  out  NCH*16  per-lane saturation counts (optional feature)

Behaviour:
- Reset: run counter 0, s_running 0, finish 0, wr_ovf 0, all write addresses/aggregators 0, sbus_rdata 0, sat_total 0. RAM contents undefined.
- Run counter: start loads run_cntr (start dominates every other event, incl. a run in progress, which restarts). Otherwise decrement by 1 on sw when nonzero. s_running = |counter (combinational). start with run_cntr=0 -> no run, no finish.
- finish = ~s_running & s_running_d1 (registered d1), exactly one cycle after the last accepted strobe's decrement.
- Data write: accepted strobe = sw & s_running. Each lane writes s_out lane to its own RAM at shared data address dadr; dadr cleared on start, +1 per accepted strobe. sw outside a run writes nothing.
- Overflow: data-address flag full set when a write lands at 2**AW-1. An accepted strobe while full -> no RAM write, no address change, wr_ovf=1. wr_ovf clears only on start or reset.
- Saturation packing: a shared bit counter bc (0..DW-1) is cleared on start. Accepted strobe k places lane c's sat into aggregator bit bc (LSB = first sample of the word). When bc=DW-1, the completed word is written to sat RAM c at sadr, sadr+1, and the aggregator is cleared. On finish with bc!=0, flush the partial word (unfilled bits 0), sadr+1. sadr saturates at 2**AW-1 like dadr and sets wr_ovf the same way.
- Simultaneous finish and start: start wins; no flush, aggregator cleared.
- Read: {ch, sel} registered alongside the RAM registered read. sbus_rdata = RAM[ch][sel] output of the previous cycle. Reads and writes to the same address in the same cycle return old data.

Optional Feature:
SBUF_SATCNT_EN defined: per-lane 16-bit counter counts accepted strobes with sat=1. Cleared on start, saturates at 16'hFFFF, drives sat_total. Undefined: sat_total tied to 0 and no counter flops.

Decomposition:
- Package sbuf_pkg: SEL_DATA=0 and SEL_SAT=1 encodings, default DW/AW/NCH/CW values, and the satcnt width (16).
- One natural sub-module: sbuf_ram_1r1w_p, a parametrised (DW, AW) 1-read/1-write RAM with registered read. 2*NCH instances via generate.

Test Plan:
- Reset mid-run: run_cntr=10, assert rst_n low after 4 strobes -> all outputs 0; next start behaves normally.
- NCH=4, run_cntr=5, lane c data = 16'h100*c + k -> finish 1 cycle after 5th strobe. Read {ch=2, sel=0, word=3} -> 16'h0203 a cycle later.
- run_cntr=20, lane 1 sat=1 on strobes 0, 15, 19 -> sat word0 = 16'h8001, flushed word1 = 16'h0008; SBUF_SATCNT_EN lane1 count = 3.
- AW=3, run_cntr=10 -> words 0..7 written, strobes 9-10 dropped, wr_ovf=1 until the next start.
- start asserted at strobe 3 of an 8-strobe run with run_cntr=2 -> addresses restart at 0, finish after 2 more strobes, no flush of the old partial.
- sw pulses while idle -> no RAM change and no counter movement; start with run_cntr=0 -> no finish pulse.

Source files
------------

// File: rtl/sbuf_pkg.sv
// Shared encodings and default geometry for the multi-channel output capture buffer.
package sbuf_pkg;

    localparam int SBUF_DW_DEF  = 16;
    localparam int SBUF_AW_DEF  = 8;
    localparam int SBUF_NCH_DEF = 4;
    localparam int SBUF_CW_DEF  = 8;
    localparam int SATCNT_W     = 16;

    typedef enum logic {
        SEL_DATA = 1'b0,
        SEL_SAT  = 1'b1
    } sbuf_sel_e;

endpackage

// File: rtl/sbuf_ram_1r1w_p.sv
// Simple dual-port RAM: one write port, one registered read port (read-before-write).
module sbuf_ram_1r1w_p #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; the array contents stay undefined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sbuf_mc.sv
// Multi-channel capture buffer: NCH data lanes plus packed saturation flags behind one read port.
// Optional per-lane saturation counters are built when SBUF_SATCNT_EN is defined.
module sbuf_mc
    import sbuf_pkg::*;
#(
    parameter int  DW  = SBUF_DW_DEF,
    parameter int  AW  = SBUF_AW_DEF,
    parameter int  NCH = SBUF_NCH_DEF,
    parameter int  CW  = SBUF_CW_DEF,
    localparam int CHW = $clog2(NCH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CHW+AW:0]         sbus_radr,
    output logic [DW-1:0]           sbus_rdata,
    input  logic [CW-1:0]           run_cntr,
    input  logic                    start,
    output logic                    s_running,
    output logic                    finish,
    input  logic [NCH*DW-1:0]       s_out,
    input  logic [NCH-1:0]          sat,
    input  logic                    sw,
    output logic                    wr_ovf,
    output logic [NCH*SATCNT_W-1:0] sat_total
);

    localparam int BCW = $clog2(DW);

    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     run_d1_q;
    logic [AW-1:0]            dadr_q, dadr_d, sadr_q, sadr_d;
    logic                     dfull_q, dfull_d, sfull_q, sfull_d;
    logic [BCW-1:0]           bc_q, bc_d;
    logic [NCH-1:0][DW-1:0]   agg_q, agg_d, sw_word;
    logic                     ovf_q, ovf_d;
    logic                     acc, dwe, swe, sat_wr;
    logic [CHW:0]             rsel_q;
    logic [DW-1:0]            drd [NCH];
    logic [DW-1:0]            srd [NCH];

    assign s_running = |cnt_q;
    assign finish    = ~s_running & run_d1_q;
    assign acc       = sw & s_running;
    assign wr_ovf    = ovf_q;

    always_comb begin
        cnt_d   = cnt_q;
        dadr_d  = dadr_q;
        dfull_d = dfull_q;
        sadr_d  = sadr_q;
        sfull_d = sfull_q;
        bc_d    = bc_q;
        agg_d   = agg_q;
        ovf_d   = ovf_q;
        dwe     = 1'b0;
        swe     = 1'b0;
        sat_wr  = 1'b0;
        sw_word = agg_q;
        if (start) begin
            cnt_d   = run_cntr;
            dadr_d  = '0;
            dfull_d = 1'b0;
            sadr_d  = '0;
            sfull_d = 1'b0;
            bc_d    = '0;
            agg_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            if (acc) begin
                cnt_d = cnt_q - CW'(1);
                if (dfull_q) begin
                    ovf_d = 1'b1;
                end else begin
                    dwe = 1'b1;
                    if (dadr_q == '1) dfull_d = 1'b1;
                    else              dadr_d  = dadr_q + AW'(1);
                end
                for (int c = 0; c < NCH; c++) begin
                    agg_d[c][bc_q] = sat[c];
                end
                if (bc_q == BCW'(DW - 1)) sat_wr = 1'b1;
                else                      bc_d   = bc_q + BCW'(1);
            end else if (finish && bc_q != '0) begin
                sat_wr = 1'b1;
            end
            // Completed or flushed word leaves the aggregator; unfilled bits are already 0.
            if (sat_wr) begin
                sw_word = agg_d;
                agg_d   = '0;
                bc_d    = '0;
                if (sfull_q) begin
                    ovf_d = 1'b1;
                end else begin
                    swe = 1'b1;
                    if (sadr_q == '1) sfull_d = 1'b1;
                    else              sadr_d  = sadr_q + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            run_d1_q <= 1'b0;
            dadr_q   <= '0;
            dfull_q  <= 1'b0;
            sadr_q   <= '0;
            sfull_q  <= 1'b0;
            bc_q     <= '0;
            agg_q    <= '0;
            ovf_q    <= 1'b0;
            rsel_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            run_d1_q <= s_running & ~start;
            dadr_q   <= dadr_d;
            dfull_q  <= dfull_d;
            sadr_q   <= sadr_d;
            sfull_q  <= sfull_d;
            bc_q     <= bc_d;
            agg_q    <= agg_d;
            ovf_q    <= ovf_d;
            rsel_q   <= sbus_radr[CHW+AW:AW];
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        sbuf_ram_1r1w_p #(.DW(DW), .AW(AW)) u_dram (
            .clk(clk), .rst_n(rst_n), .we(dwe), .waddr(dadr_q),
            .wdata(s_out[c*DW +: DW]), .raddr(sbus_radr[AW-1:0]), .rdata(drd[c])
        );
        sbuf_ram_1r1w_p #(.DW(DW), .AW(AW)) u_sram (
            .clk(clk), .rst_n(rst_n), .we(swe), .waddr(sadr_q),
            .wdata(sw_word[c]), .raddr(sbus_radr[AW-1:0]), .rdata(srd[c])
        );
    end

    // Read port: address presented in cycle N, data returned in cycle N+1.
    always_comb begin
        sbus_rdata = drd[rsel_q[CHW:1]];
        if (sbuf_sel_e'(rsel_q[0]) == SEL_SAT) sbus_rdata = srd[rsel_q[CHW:1]];
    end

`ifdef SBUF_SATCNT_EN
    logic [NCH-1:0][SATCNT_W-1:0] scnt_q, scnt_d;

    always_comb begin
        scnt_d = scnt_q;
        for (int c = 0; c < NCH; c++) begin
            if (start)                                 scnt_d[c] = '0;
            else if (acc && sat[c] && scnt_q[c] != '1) scnt_d[c] = scnt_q[c] + SATCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) scnt_q <= '0;
        else        scnt_q <= scnt_d;
    end

    assign sat_total = scnt_q;
`else
    assign sat_total = '0;
`endif

endmodule

// File: tb/tb_sbuf_mc.sv
// Randomised scoreboard bench for sbuf_mc; a default-depth and a depth-8 instance share stimulus.
module tb_sbuf_mc;
    import sbuf_pkg::*;

    localparam int DW = 16, NCH = 4, CW = 8, AWB = 8, AWS = 3;

    logic          clk, rst_n, start, sw;
    logic [CW-1:0] run_cntr;
    logic [63:0]   s_out;
    logic [3:0]    sat;
    logic [10:0]   radr_b;
    logic [5:0]    radr_s;
    logic [15:0]   rdata_b, rdata_s;
    logic          run_b, run_s, fin_b, fin_s, ovf_b, ovf_s;
    logic [63:0]   st_b, st_s;

    sbuf_mc #(.DW(DW), .AW(AWB), .NCH(NCH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .sbus_radr(radr_b), .sbus_rdata(rdata_b),
        .run_cntr(run_cntr), .start(start), .s_running(run_b), .finish(fin_b),
        .s_out(s_out), .sat(sat), .sw(sw), .wr_ovf(ovf_b), .sat_total(st_b)
    );

    sbuf_mc #(.DW(DW), .AW(AWS), .NCH(NCH), .CW(CW)) dut_s (
        .clk(clk), .rst_n(rst_n), .sbus_radr(radr_s), .sbus_rdata(rdata_s),
        .run_cntr(run_cntr), .start(start), .s_running(run_s), .finish(fin_s),
        .s_out(s_out), .sat(sat), .sw(sw), .wr_ovf(ovf_s), .sat_total(st_s)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          depth [2] = '{256, 8};
    logic [15:0] m_dmem [2][NCH][256];
    bit          m_dv   [2][NCH][256];
    logic [15:0] m_smem [2][NCH][256];
    bit          m_sv   [2][NCH][256];
    bit          m_ovf  [2];
    logic [15:0] m_part [NCH];
    int          m_scnt [NCH];
    int          m_cnt, m_k;
    bit          m_fin;

    logic [15:0] exp_q_b[$], exp_q_s[$];
    bit          rd_req_b, rd_req_s, rd_pend_b, rd_pend_s;
    int          total, bad;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_k = 0; m_fin = 0;
        for (int i = 0; i < 2; i++) begin
            m_ovf[i] = 0;
            for (int c = 0; c < NCH; c++)
                for (int a = 0; a < 256; a++) begin
                    m_dv[i][c][a] = 0;
                    m_sv[i][c][a] = 0;
                end
        end
        for (int c = 0; c < NCH; c++) begin
            m_part[c] = '0;
            m_scnt[c] = 0;
        end
    endtask

    task automatic sat_word_write(input int w);
        for (int i = 0; i < 2; i++) begin
            if (w < depth[i]) begin
                for (int c = 0; c < NCH; c++) begin
                    m_smem[i][c][w] = m_part[c];
                    m_sv[i][c][w]   = 1;
                end
            end else begin
                m_ovf[i] = 1;
            end
        end
        for (int c = 0; c < NCH; c++) m_part[c] = '0;
    endtask

    // Effect of one clock edge, given the inputs currently applied.
    task automatic model_edge(input bit st, input int rc, input bit s);
        bit acc, fin_next;
        acc = s && (m_cnt > 0) && !st;
        fin_next = 0;
        if (st) begin
            m_cnt = rc; m_k = 0;
            m_ovf[0] = 0; m_ovf[1] = 0;
            for (int c = 0; c < NCH; c++) begin
                m_part[c] = '0;
                m_scnt[c] = 0;
            end
        end else begin
            if (m_fin && (m_k % DW) != 0) sat_word_write(m_k / DW);
            if (acc) begin
                for (int c = 0; c < NCH; c++) begin
                    for (int i = 0; i < 2; i++) begin
                        if (m_k < depth[i]) begin
                            m_dmem[i][c][m_k] = s_out[c*DW +: DW];
                            m_dv[i][c][m_k]   = 1;
                        end else begin
                            m_ovf[i] = 1;
                        end
                    end
                    m_part[c][m_k % DW] = sat[c];
                    if (sat[c] && m_scnt[c] < 65535) m_scnt[c]++;
                end
                if ((m_k % DW) == DW - 1) sat_word_write(m_k / DW);
                m_k++;
                m_cnt--;
                fin_next = (m_cnt == 0);
            end
        end
        m_fin = fin_next;
    endtask

    function automatic logic [63:0] exp_sat_total();
        logic [63:0] e;
        e = '0;
`ifdef SBUF_SATCNT_EN
        for (int c = 0; c < NCH; c++) e[c*16 +: 16] = m_scnt[c][15:0];
`endif
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic cyc(input bit st, input int rc, input bit s,
                       input bit rd = 0, input int ch = 0, input int sel = 0, input int word = 0);
        int ws;
        start = st; run_cntr = CW'(rc); sw = s;
        rd_req_b = 0; rd_req_s = 0;
        if (rd) begin
            radr_b = {2'(ch), 1'(sel), 8'(word)};
            radr_s = {2'(ch), 1'(sel), 3'(word)};
            ws = word % 8;
            if (sel == 0) begin
                if (m_dv[0][ch][word]) begin exp_q_b.push_back(m_dmem[0][ch][word]); rd_req_b = 1; end
                if (m_dv[1][ch][ws])   begin exp_q_s.push_back(m_dmem[1][ch][ws]);   rd_req_s = 1; end
            end else begin
                if (m_sv[0][ch][word]) begin exp_q_b.push_back(m_smem[0][ch][word]); rd_req_b = 1; end
                if (m_sv[1][ch][ws])   begin exp_q_s.push_back(m_smem[1][ch][ws]);   rd_req_s = 1; end
            end
        end
        @(negedge clk);
        chk("s_running_b", run_b, m_cnt != 0);
        chk("s_running_s", run_s, m_cnt != 0);
        chk("finish_b", fin_b, m_fin);
        chk("finish_s", fin_s, m_fin);
        chk("wr_ovf_b", ovf_b, m_ovf[0]);
        chk("wr_ovf_s", ovf_s, m_ovf[1]);
        chk("sat_total", st_b, exp_sat_total());
        model_edge(st, rc, s);
        @(posedge clk);
        #1;
        rd_req_b = 0; rd_req_s = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    task automatic rd(input int ch, input int sel, input int word);
        cyc(0, 0, 0, 1, ch, sel, word);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_rdata_b", rdata_b, 0);
        chk("rst_rdata_s", rdata_s, 0);
        chk("rst_running", run_b, 0);
        chk("rst_finish", fin_b, 0);
        chk("rst_ovf_b", ovf_b, 0);
        chk("rst_ovf_s", ovf_s, 0);
        chk("rst_sat_total", st_b, 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        rd_pend_b <= rd_req_b;
        rd_pend_s <= rd_req_s;
    end

    always @(negedge clk) begin
        if (rd_pend_b) begin
            if (exp_q_b.size() == 0) chk("rd_b_underflow", 1, 0);
            else                     chk("rd_b", rdata_b, exp_q_b.pop_front());
        end
        if (rd_pend_s) begin
            if (exp_q_s.size() == 0) chk("rd_s_underflow", 1, 0);
            else                     chk("rd_s", rdata_s, exp_q_s.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        total = 0; bad = 0;
        rst_n = 0; start = 0; sw = 0; run_cntr = '0; s_out = '0; sat = '0;
        radr_b = '0; radr_s = '0; rd_req_b = 0; rd_req_s = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;

        // reset in the middle of a run
        cyc(1, 10, 0);
        for (int k = 0; k < 4; k++) begin s_out = {$urandom, $urandom}; sat = 4'hF; cyc(0, 0, 1); end
        rst_n = 0;
        #2;
        chk_reset_outputs();
        model_reset();
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;

        // 5-strobe run with structured lane data
        sat = '0;
        cyc(1, 5, 0);
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < NCH; c++) s_out[c*16 +: 16] = 16'((16'h100 * c) + k);
            cyc(0, 0, 1);
            cyc(0, 0, 0);
        end
        idle(2);
        rd(2, 0, 3);
        rd(0, 0, 0);
        rd(3, 0, 4);

        // saturation packing with partial flush
        cyc(1, 20, 0);
        for (int k = 0; k < 20; k++) begin
            s_out = {$urandom, $urandom};
            sat = (k == 0 || k == 15 || k == 19) ? 4'b0010 : 4'b0000;
            cyc(0, 0, 1);
        end
        sat = '0;
        idle(2);
        rd(1, 1, 0);
        rd(1, 1, 1);
        rd(0, 1, 0);

        // overflow on the depth-8 instance
        cyc(1, 10, 0);
        for (int k = 0; k < 10; k++) begin s_out = {$urandom, $urandom}; cyc(0, 0, 1); end
        idle(2);
        for (int w = 0; w < 10; w++) rd(w % 4, 0, w);

        // restart mid-run
        cyc(1, 8, 0);
        for (int k = 0; k < 3; k++) begin s_out = {$urandom, $urandom}; sat = 4'($urandom); cyc(0, 0, 1); end
        s_out = {$urandom, $urandom}; cyc(1, 2, 1);
        for (int k = 0; k < 2; k++) begin s_out = {$urandom, $urandom}; sat = 4'($urandom); cyc(0, 0, 1); end
        idle(2);
        rd(0, 0, 0); rd(1, 0, 1); rd(2, 0, 2); rd(3, 1, 0);

        // finish and start together: no flush
        cyc(1, 3, 0);
        for (int k = 0; k < 3; k++) begin sat = 4'hF; cyc(0, 0, 1); end
        cyc(1, 0, 0);
        idle(2);
        rd(0, 1, 0); rd(3, 1, 0);

        // idle strobes and zero-length run
        for (int k = 0; k < 3; k++) begin s_out = {$urandom, $urandom}; cyc(0, 0, 1); end
        cyc(1, 0, 1);
        idle(2);
        rd(0, 0, 0); rd(1, 0, 1);

        // long run: saturation word overflow on the depth-8 instance
        cyc(1, 150, 0);
        for (int k = 0; k < 150; k++) begin s_out = {$urandom, $urandom}; sat = 4'($urandom); cyc(0, 0, 1); end
        idle(2);
        for (int w = 0; w < 10; w++) rd(w % 4, 1, w);

        // random runs
        for (int r = 0; r < 30; r++) begin
            cyc(1, $urandom_range(0, 40), 0);
            for (int n = 0; n < 200 && m_cnt > 0; n++) begin
                s_out = {$urandom, $urandom};
                sat = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 59) == 0)
                    cyc(1, $urandom_range(0, 20), 1);
                else
                    cyc(0, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                        $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 15));
            end
            idle(2);
            for (int i = 0; i < 6; i++) rd($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 40));
        end

        idle(3);
        chk("scoreboard_drained", exp_q_b.size() + exp_q_s.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
